wb_port_arbiter: RTL and testbench

- Shares the scoreboard's NR_WB_PORTS writeback ports among NR_REQ functional-unit result sources (ALU/branch, LSU load, LSU store, mult, FPU, CVXIF).
- Sits between the execute-stage units and the issue stage's trans_id/wbdata/ex/wt_valid writeback inputs.
- Multi-grant round-robin per cycle with valid/ready handshakes toward the units and registered outputs toward the scoreboard.

---
 rtl/wb_port_arbiter_pkg.sv | 27 ++
 rtl/wb_port_arbiter_if.sv | 28 ++
 rtl/wb_rr_picker.sv | 48 ++++
 rtl/wb_port_arbiter.sv | 112 +++++++++++
 tb/tb_wb_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the writeback port arbiter: result payload and
// exception records, plus the round-robin pointer width helper.
package wb_port_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    xlen_t                    data;
    exception_t               ex;
  } wb_req_t;

  // Pointer width for a round-robin over nr_req sources; never narrower than 1 bit.
  function automatic int unsigned wb_arb_rr_bits(int unsigned nr_req);
    return (nr_req > 1) ? $clog2(nr_req) : 1;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Result-source and scoreboard-writeback bundle of the writeback port arbiter.
// master = units/scoreboard side, slave = arbiter side.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ      = 6,
  parameter int unsigned NR_WB_PORTS = 4
) ();

  logic [NR_REQ-1:0]                           req_valid;
  logic [NR_REQ-1:0]                           req_ready;
  wb_req_t [NR_REQ-1:0]                        req;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id;
  xlen_t [NR_WB_PORTS-1:0]                     wbdata;
  exception_t [NR_WB_PORTS-1:0]                ex;
  logic [NR_WB_PORTS-1:0]                      wt_valid;

  modport master (
    output req_valid, req,
    input  req_ready, trans_id, wbdata, ex, wt_valid
  );

  modport slave (
    input  req_valid, req,
    output req_ready, trans_id, wbdata, ex, wt_valid
  );

endinterface

// File: rtl/wb_rr_picker.sv
// Combinational multi-grant round-robin picker: scans from rr_ptr_i and grants the
// first NR_WB_PORTS valid sources, packing them into ports in scan order.
module wb_rr_picker
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ      = 6,
  parameter int unsigned NR_WB_PORTS = 4,
  localparam int unsigned RR_BITS    = wb_arb_rr_bits(NR_REQ)
) (
  input  logic [NR_REQ-1:0]                     valid_i,
  input  logic [RR_BITS-1:0]                    rr_ptr_i,
  output logic [NR_REQ-1:0]                     grant_o,
  output logic [NR_WB_PORTS-1:0][RR_BITS-1:0]   port_src_o,
  output logic [NR_WB_PORTS-1:0]                port_valid_o,
  output logic [RR_BITS-1:0]                    rr_ptr_next_o
);

  localparam int unsigned PORT_BITS = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
  localparam int unsigned CNT_W     = PORT_BITS + 1;

  logic [CNT_W-1:0]   w_cnt;
  logic [RR_BITS-1:0] w_idx;
  int unsigned        w_sum;

  always_comb begin
    grant_o       = '0;
    port_src_o    = '0;
    port_valid_o  = '0;
    rr_ptr_next_o = rr_ptr_i;
    w_cnt         = '0;
    w_idx         = '0;
    w_sum         = 0;
    for (int unsigned k = 0; k < NR_REQ; k++) begin
      w_sum = 32'(rr_ptr_i) + k;
      if (w_sum >= NR_REQ) w_sum = w_sum - NR_REQ;
      w_idx = RR_BITS'(w_sum);
      if (valid_i[w_idx] && (w_cnt < CNT_W'(NR_WB_PORTS))) begin
        grant_o[w_idx]                    = 1'b1;
        port_src_o[w_cnt[PORT_BITS-1:0]]   = w_idx;
        port_valid_o[w_cnt[PORT_BITS-1:0]] = 1'b1;
        // Next scan starts just past the most recent grant.
        rr_ptr_next_o = (w_idx == RR_BITS'(NR_REQ - 1)) ? '0 : w_idx + RR_BITS'(1);
        w_cnt         = w_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares NR_WB_PORTS scoreboard writeback ports among NR_REQ result sources with
// registered outputs. Optional stall statistics under WB_PORT_ARBITER_PERF_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned NR_REQ      = 6,
  parameter int unsigned NR_WB_PORTS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  wb_port_arbiter_if.slave         bus
`ifdef WB_PORT_ARBITER_PERF_EN
  ,
  output logic [NR_REQ-1:0][15:0]  stall_cnt_o,
  output logic [NR_REQ-1:0][7:0]   max_wait_o
`endif
);

  localparam int unsigned RR_BITS = wb_arb_rr_bits(NR_REQ);

  logic [NR_REQ-1:0]                         w_grant;
  logic [NR_WB_PORTS-1:0][RR_BITS-1:0]       w_port_src;
  logic [NR_WB_PORTS-1:0]                    w_port_valid;
  logic [RR_BITS-1:0]                        w_rr_next;

  logic [RR_BITS-1:0]                        r_rr_ptr;
  logic [NR_WB_PORTS-1:0]                    r_wt_valid;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] r_trans_id;
  xlen_t [NR_WB_PORTS-1:0]                   r_wbdata;
  exception_t [NR_WB_PORTS-1:0]              r_ex;

  wb_rr_picker #(
    .NR_REQ      (NR_REQ),
    .NR_WB_PORTS (NR_WB_PORTS)
  ) u_picker (
    .valid_i       (bus.req_valid),
    .rr_ptr_i      (r_rr_ptr),
    .grant_o       (w_grant),
    .port_src_o    (w_port_src),
    .port_valid_o  (w_port_valid),
    .rr_ptr_next_o (w_rr_next)
  );

  // On flush every pending result is accepted and dropped.
  assign bus.req_ready = flush_i ? bus.req_valid : w_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr_ptr   <= '0;
      r_wt_valid <= '0;
      r_trans_id <= '0;
      r_wbdata   <= '0;
      r_ex       <= '0;
    end else if (flush_i) begin
      r_wt_valid <= '0;
    end else begin
      r_rr_ptr   <= w_rr_next;
      r_wt_valid <= w_port_valid;
      for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
        if (w_port_valid[k]) begin
          r_trans_id[k] <= bus.req[w_port_src[k]].trans_id;
          r_wbdata[k]   <= bus.req[w_port_src[k]].data;
          r_ex[k]       <= bus.req[w_port_src[k]].ex;
        end
      end
    end
  end

  assign bus.trans_id = r_trans_id;
  assign bus.wbdata   = r_wbdata;
  assign bus.ex       = r_ex;
  assign bus.wt_valid = r_wt_valid;

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [NR_REQ-1:0]       w_stall;
  logic [NR_REQ-1:0][7:0]  w_run_inc;
  logic [NR_REQ-1:0][15:0] r_stall_cnt;
  logic [NR_REQ-1:0][7:0]  r_run;
  logic [NR_REQ-1:0][7:0]  r_max_wait;

  always_comb begin
    w_stall   = bus.req_valid & ~bus.req_ready & {NR_REQ{~flush_i}};
    w_run_inc = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      w_run_inc[i] = (r_run[i] == 8'hFF) ? 8'hFF : r_run[i] + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_run       <= '0;
      r_max_wait  <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (w_stall[i]) begin
          if (r_stall_cnt[i] != 16'hFFFF) r_stall_cnt[i] <= r_stall_cnt[i] + 16'd1;
          r_run[i] <= w_run_inc[i];
          if (w_run_inc[i] > r_max_wait[i]) r_max_wait[i] <= w_run_inc[i];
        end else begin
          r_run[i] <= '0;
        end
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign max_wait_o  = r_max_wait;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a 4-port and a 1-port instance, expected
// writebacks queued at drive time and compared one cycle later.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  always #5 clk_i = ~clk_i;

  wb_port_arbiter_if #(.NR_REQ(6), .NR_WB_PORTS(4)) u_if4 ();
  wb_port_arbiter_if #(.NR_REQ(6), .NR_WB_PORTS(1)) u_if1 ();

`ifdef WB_PORT_ARBITER_PERF_EN
  logic [5:0][15:0] sc4, sc1;
  logic [5:0][7:0]  mw4, mw1;
`endif

  wb_port_arbiter #(.NR_REQ(6), .NR_WB_PORTS(4)) u_dut4 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (u_if4)
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    .stall_cnt_o (sc4),
    .max_wait_o  (mw4)
`endif
  );

  wb_port_arbiter #(.NR_REQ(6), .NR_WB_PORTS(1)) u_dut1 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (u_if1)
`ifdef WB_PORT_ARBITER_PERF_EN
    ,
    .stall_cnt_o (sc1),
    .max_wait_o  (mw1)
`endif
  );

  typedef struct {
    logic [3:0]        wt;
    logic [3:0][2:0]   tid;
    logic [3:0][63:0]  data;
    exception_t [3:0]  ex;
    bit                all;
  } exp_t;

  exp_t    q[$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      m_ptr4  = 0;
  int      m_ptr1  = 0;
  wb_req_t pay4[6];
  wb_req_t pay1[6];
  logic [5:0] hs;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic wb_req_t new_payload();
    wb_req_t p;
    p.trans_id = 3'($urandom);
    p.data     = {$urandom, $urandom};
    p.ex.cause = {$urandom, $urandom};
    p.ex.tval  = {$urandom, $urandom};
    p.ex.valid = 1'($urandom);
    return p;
  endfunction

  // Reference: walk requesters in round-robin order from ptr, fill ports in order.
  function automatic void model(input logic [5:0] v, input int ports, inout int ptr,
                                output logic [5:0] g, output logic [3:0][2:0] src,
                                output logic [3:0] pv);
    int n = 0;
    int start = ptr;
    g = '0; src = '0; pv = '0;
    for (int k = 0; k < 6; k++) begin
      int i = (start + k) % 6;
      if (v[i] && n < ports) begin
        g[i]   = 1'b1;
        src[n] = 3'(i);
        pv[n]  = 1'b1;
        n++;
        ptr = (i + 1) % 6;
      end
    end
  endfunction

  task automatic drive_payloads();
    for (int i = 0; i < 6; i++) begin
      u_if4.req[i] = pay4[i];
      u_if1.req[i] = pay1[i];
    end
  endtask

  // One clock: check ready, queue expected writeback, compare after the edge.
  task automatic step(input bit one, input bit do_rst);
    logic [5:0] v, rdy, g;
    logic [3:0][2:0] src;
    logic [3:0] pv, wt;
    int p, ports;
    exp_t e, o;
    wb_req_t pl;
    ports = one ? 1 : 4;
    #1;
    v   = one ? u_if1.req_valid : u_if4.req_valid;
    rdy = one ? u_if1.req_ready : u_if4.req_ready;
    p   = one ? m_ptr1 : m_ptr4;
    model(v, ports, p, g, src, pv);
    e.wt = '0; e.tid = '0; e.data = '0; e.ex = '0; e.all = 1'b0;
    if (!do_rst) check_eq(flush_i ? "ready_flush" : "ready", 256'(rdy), 256'(flush_i ? v : g));
    if (do_rst) begin
      e.all  = 1'b1;
      m_ptr1 = 0;
      m_ptr4 = 0;
    end else if (!flush_i) begin
      if (one) m_ptr1 = p; else m_ptr4 = p;
      e.wt = pv;
      for (int k = 0; k < ports; k++) begin
        if (pv[k]) begin
          pl = one ? pay1[src[k]] : pay4[src[k]];
          e.tid[k]  = pl.trans_id;
          e.data[k] = pl.data;
          e.ex[k]   = pl.ex;
        end
      end
    end
    q.push_back(e);
    @(posedge clk_i);
    #1;
    o  = q.pop_front();
    wt = one ? {3'b000, u_if1.wt_valid} : u_if4.wt_valid;
    check_eq("wt_valid", 256'(wt), 256'(o.wt));
    for (int k = 0; k < ports; k++) begin
      if (o.all || o.wt[k]) begin
        check_eq("trans_id", 256'(one ? u_if1.trans_id[0] : u_if4.trans_id[k]), 256'(o.tid[k]));
        check_eq("wbdata", 256'(one ? u_if1.wbdata[0] : u_if4.wbdata[k]), 256'(o.data[k]));
        check_eq("ex", 256'(one ? u_if1.ex[0] : u_if4.ex[k]), 256'(o.ex[k]));
      end
    end
    hs = v & rdy;
    for (int i = 0; i < 6; i++) begin
      if (hs[i]) begin
        if (one) pay1[i] = new_payload(); else pay4[i] = new_payload();
      end
    end
    drive_payloads();
  endtask

  initial begin
    int got;
    logic [5:0] v;
    for (int i = 0; i < 6; i++) begin
      pay4[i] = new_payload();
      pay1[i] = new_payload();
    end
    drive_payloads();
    u_if4.req_valid = '0;
    u_if1.req_valid = '0;
    flush_i = 1'b0;
    rst_i   = 1'b1;
    step(0, 1);
    step(0, 1);
    rst_i = 1'b0;

    // Single request 2 with a known payload.
    pay4[2] = '0;
    pay4[2].trans_id = 3'd5;
    pay4[2].data     = 64'hDEAD;
    drive_payloads();
    u_if4.req_valid = 6'b000100;
    step(0, 0);
    check_eq("tp1_hs", 256'(hs), 256'(6'b000100));
    check_eq("tp1_tid", 256'(u_if4.trans_id[0]), 256'(3'd5));
    check_eq("tp1_data", 256'(u_if4.wbdata[0]), 256'(64'hDEAD));
    // Pointer must now be 3: all-valid scan grants 3,4,5,0.
    u_if4.req_valid = 6'b111111;
    step(0, 0);
    check_eq("ptr3_hs", 256'(hs), 256'(6'b111001));

    // All valid from pointer 0.
    rst_i = 1'b1;
    step(0, 1);
    rst_i = 1'b0;
    u_if4.req_valid = 6'b111111;
    step(0, 0);
    check_eq("rr_c0", 256'(hs), 256'(6'b001111));
    step(0, 0);
    check_eq("rr_c1", 256'(hs), 256'(6'b110011));
    step(0, 0);
    check_eq("rr_c2", 256'(hs), 256'(6'b111100));
    check_eq("rr_wt", 256'(u_if4.wt_valid), 256'(4'b1111));

    // Sparse: only 1 and 4.
    u_if4.req_valid = 6'b010010;
    step(0, 0);
    check_eq("sparse_wt", 256'(u_if4.wt_valid), 256'(4'b0011));

    // Flush with 0 and 3 valid; pointer must stay put afterwards.
    u_if4.req_valid = 6'b001001;
    flush_i = 1'b1;
    step(0, 0);
    flush_i = 1'b0;
    check_eq("flush_wt", 256'(u_if4.wt_valid), 256'(4'b0000));
    u_if4.req_valid = 6'b111111;
    step(0, 0);

    // Reset while three ports are live.
    u_if4.req_valid = 6'b000111;
    step(0, 0);
    check_eq("pre_rst_wt", 256'(u_if4.wt_valid), 256'(4'b0111));
    u_if4.req_valid = 6'b111111;
    rst_i = 1'b1;
    step(0, 1);
    rst_i = 1'b0;
    u_if4.req_valid = 6'b000001;
    step(0, 0);
    check_eq("post_rst_wt", 256'(u_if4.wt_valid), 256'(4'b0001));

    // Random traffic; a valid requester holds until accepted.
    v = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (!v[i] || hs[i]) v[i] = 1'($urandom_range(0, 1));
      end
      u_if4.req_valid = v;
      flush_i = ($urandom_range(0, 15) == 0);
      step(0, 0);
    end
    flush_i = 1'b0;
    u_if4.req_valid = '0;

    // One-port instance: requester 5 must win by the sixth cycle.
    rst_i = 1'b1;
    step(1, 1);
    rst_i = 1'b0;
    u_if1.req_valid = 6'b111111;
    got = -1;
    for (int c = 0; c < 6 && got < 0; c++) begin
      step(1, 0);
      if (hs[5]) got = c;
    end
    check_eq("fair5", 256'(got), 256'(5));
`ifdef WB_PORT_ARBITER_PERF_EN
    check_eq("stall_cnt5", 256'(sc1[5]), 256'(16'd5));
    check_eq("max_wait5", 256'(mw1[5]), 256'(8'd5));
`endif
    u_if1.req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
